stopwatch_ctrl: RTL



---
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle between the stopwatch controller and its decade digit counters.
// Signal names carry the controller's point of view (i_ = into the controller).
interface stopwatch_ctrl_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic                  i_start;
    logic                  i_stop;
    logic                  i_clr;
    logic                  i_load_req;
    logic [4*DIGITS-1:0]   i_preset;
    logic [DIGITS-1:0]     i_digit_count;
    logic [DIGITS-1:0]     o_digit_en;
    logic                  o_digit_load_n;
    logic [4*DIGITS-1:0]   o_digit_data;
    logic                  o_tick;
    logic                  o_running;
    logic                  o_ovf;

    modport slave (
        input  i_start, i_stop, i_clr, i_load_req, i_preset, i_digit_count,
        output o_digit_en, o_digit_load_n, o_digit_data, o_tick, o_running, o_ovf
    );

    modport master (
        output i_start, i_stop, i_clr, i_load_req, i_preset, i_digit_count,
        input  o_digit_en, o_digit_load_n, o_digit_data, o_tick, o_running, o_ovf
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: time-base prescaler, run/pause/clear FSM and per-digit EN/LOAD/DATA
// drive for a cascade of external mod-10 counters.
module stopwatch_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned PRESCALE    = 10,
    parameter bit          STOP_AT_MAX = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    stopwatch_ctrl_if.slave   bus
);
    localparam int unsigned      PW        = $clog2(PRESCALE);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRun     = 3'd1;
    localparam logic [2:0] StPause   = 3'd2;
    localparam logic [2:0] StLoading = 3'd3;
    localparam logic [2:0] StHalt    = 3'd4;

    logic [2:0]          r_state, w_state_nxt;
    logic [PW-1:0]       r_presc, w_presc_nxt;
    logic                r_ovf, w_ovf_nxt;
    logic [4*DIGITS-1:0] r_data, w_data_nxt;

    logic              w_tick, w_all9, w_halt, w_inc, w_carry;
    logic [DIGITS-1:0] w_cascade;

    always_comb begin
        w_tick  = (r_state == StRun) && (r_presc == PRESC_MAX);
        w_all9  = &bus.i_digit_count;
        w_halt  = w_tick && w_all9 && STOP_AT_MAX;
        // A coincident clear or a halt at all-9s swallows the increment.
        w_inc   = w_tick && !bus.i_clr && !w_halt;
        w_carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_cascade[i] = w_inc && w_carry;
            w_carry      = w_carry && bus.i_digit_count[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_ovf_nxt   = r_ovf;
        w_data_nxt  = r_data;
        if (r_state == StRun) begin
            w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        end
        if (bus.i_clr) begin
            w_state_nxt = StLoading;
            w_data_nxt  = '0;
            w_ovf_nxt   = 1'b0;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                StIdle, StPause, StHalt: begin
                    if (bus.i_load_req) begin
                        w_state_nxt = StLoading;
                        w_data_nxt  = bus.i_preset;
                        w_presc_nxt = '0;
                    end else if (!bus.i_stop && bus.i_start && r_state != StHalt) begin
                        w_state_nxt = StRun;
                        if (r_state == StIdle) w_presc_nxt = '0;
                    end
                end
                StRun: begin
                    if (w_halt) begin
                        w_state_nxt = StHalt;
                        w_ovf_nxt   = 1'b1;
                    end else begin
                        if (w_tick && w_all9) w_ovf_nxt = 1'b1;
                        if (bus.i_stop) w_state_nxt = StPause;
                    end
                end
                StLoading: begin
                    w_state_nxt = StIdle;
                    w_presc_nxt = '0;
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_presc <= '0;
            r_ovf   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign bus.o_tick         = w_tick;
    assign bus.o_running      = (r_state == StRun);
    assign bus.o_digit_load_n = (r_state != StLoading);
    assign bus.o_digit_en     = (r_state == StLoading) ? '1 : w_cascade;
    assign bus.o_digit_data   = r_data;
    assign bus.o_ovf          = r_ovf;
endmodule
